adc_result_decimator: RTL and testbench
=======================================

Name: adc_result_decimator

Overview:
- Sits directly downstream of the SAR ADC control block and consumes its per-conversion `result` word and `conv_finished` strobe.
- Accumulates 2^osr consecutive conversions into one oversampled word, normalised to a fixed output width.
- Buffers the decimated words in a small first-word-fall-through FIFO with a valid/ready handshake toward the digital consumer (wishbone/logic-analyzer side).

Parameters:
- DATA_BITS, 12: width of the incoming conversion result.
- OSR_MAX_LOG2, 4: maximum log2 oversampling ratio. Output width OUT_BITS = DATA_BITS+OSR_MAX_LOG2.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk, input, 1: clock, shared with the ADC controller.
- rst, input, 1: synchronous reset, active-high.
- conv_finished, input, 1: high while the controller holds a completed result.
- result, input, DATA_BITS: conversion result; valid in the cycle conv_finished rises.
- osr_control, input, 3: requested log2 oversampling ratio.
- data_out, output, OUT_BITS: head-of-FIFO decimated word.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer accepts data_out.
- fifo_level, output, clog2(FIFO_DEPTH)+1: number of stored words.
- overflow, output, 1: sticky flag, a frame was dropped.
- overflow_clr, input, 1: clears overflow.

Behaviour:
- Reset (rst=1 sampled at clk edge) sets:
  - accumulator=0, sample count=0, active osr=0, FIFO pointers=0.
  - out_valid=0, fifo_level=0, overflow=0, data_out=0.
  - conv_finished_d=1, discard_first=1.
- Reset mid-frame discards partial sums and FIFO contents; no frame is pushed in the reset cycle.
- Strobe: strobe = conv_finished & ~conv_finished_d, where conv_finished_d is a 1-cycle registered copy. A multi-cycle-high conv_finished produces one strobe.
- First strobe after reset:
  - Consumed with no accumulation; clears discard_first.
  - Rationale: the controller's power-on result is meaningless.
- Active osr:
  - osr_eff = min(osr_control, OSR_MAX_LOG2).
  - Latched only at frame start: at reset release, and on the edge completing a frame.
  - osr_control changes mid-frame take effect from the next frame.
- On each accepted strobe with count < 2^osr_act - 1: acc <= acc + result; count <= count + 1.
- On a strobe with count == 2^osr_act - 1:
  - Frame completes: word = (acc + result) << (OSR_MAX_LOG2 - osr_act).
  - Word is pushed into the FIFO on the same edge; acc <= 0; count <= 0; osr_act <= osr_eff.
- Arithmetic: the accumulator is OUT_BITS wide, unsigned, and cannot overflow since the maximum sum is 2^OSR_MAX_LOG2*(2^DATA_BITS-1). Shift is logical left.
- Latency: if the FIFO is empty, out_valid and data_out are valid the cycle after the edge at which conv_finished was first sampled high for the completing conversion (1 clock).
- FIFO (first-word-fall-through):
  - Pop when out_valid & out_ready.
  - data_out holds the head word stable while out_valid=1 and out_ready=0.
  - When empty, data_out holds its last value and out_valid=0.
  - out_ready while empty is ignored.
- FIFO full with push and no pop: the new word is dropped, overflow <= 1, and the stored contents are unchanged.
- FIFO full with push and pop in the same cycle: both occur and the level stays FIFO_DEPTH; no overflow.
- Pointers wrap modulo FIFO_DEPTH; the extra level bit distinguishes full from empty.
- overflow:
  - overflow_clr=1 clears it.
  - If overflow_clr and a new drop occur in the same cycle, overflow ends at 1 (set wins).

Test Plan:
- Reset, osr_control=0, out_ready=1, strobe results 0x7FF (discarded) then 0x123 -> one word data_out=0x1230, out_valid high for 1 cycle, 1 clock after the second strobe.
- osr_control=2, strobes with results 100,101,102,103 after the discard -> single word 406<<2=1624 (0x658); no word after only 3 strobes.
- osr_control=7 -> clamped to 4: 16 strobes of 0xFFF give data_out=0xFFF0; 15 strobes give nothing.
- out_ready=0, osr=0, five strobes with results 1..5 -> fifo_level=4, overflow=1, then popping yields 0x10,0x20,0x30,0x40 and out_valid=0; overflow_clr -> overflow=0.
- osr=2, after 2 strobes change osr_control to 0 -> current frame still takes 4 samples (shifted by 2), following frames are single-sample.
- Assert rst mid-frame with FIFO holding 2 words -> next cycle fifo_level=0, out_valid=0, overflow=0; the next strobe is discarded.

Source files
------------

// File: rtl/adc_result_decimator.sv
// adc_result_decimator: oversampling accumulator for SAR ADC results feeding a
// small first-word-fall-through FIFO with a valid/ready output handshake.
module adc_result_decimator #(
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned OSR_MAX_LOG2 = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                conv_finished,
  input  logic [DATA_BITS-1:0]                result,
  input  logic [2:0]                          osr_control,
  output logic [DATA_BITS+OSR_MAX_LOG2-1:0]   data_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic                                overflow,
  input  logic                                overflow_clr
);

  localparam int unsigned OUT_BITS = DATA_BITS + OSR_MAX_LOG2;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned LW       = AW + 1;
  localparam int unsigned CNT_W    = OSR_MAX_LOG2;

  logic                conv_d;
  logic                discard_first;
  logic                start_pending;
  logic [2:0]          osr_act;
  logic [2:0]          osr_eff;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    cnt_limit;
  logic [OUT_BITS-1:0] acc;
  logic [OUT_BITS-1:0] sum;
  logic [OUT_BITS-1:0] word;
  logic                strobe;
  logic                sample;
  logic                frame_done;
  logic                full;
  logic                pop;
  logic                drop;
  logic                wr_en;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       rd_next;
  logic [LW-1:0]       level_next;
  logic [OUT_BITS-1:0] mem [FIFO_DEPTH];

  // Strobe detection, frame arithmetic and FIFO push/pop decisions.
  always_comb begin
    osr_eff    = (32'(osr_control) > OSR_MAX_LOG2) ? 3'(OSR_MAX_LOG2) : osr_control;
    strobe     = conv_finished & ~conv_d;
    sample     = strobe & ~discard_first;
    cnt_limit  = CNT_W'((32'd1 << osr_act) - 32'd1);
    frame_done = sample & (count == cnt_limit);
    sum        = acc + OUT_BITS'(result);
    word       = sum << (3'(OSR_MAX_LOG2) - osr_act);
    full       = (fifo_level == LW'(FIFO_DEPTH));
    pop        = out_valid & out_ready;
    drop       = frame_done & full & ~pop;
    wr_en      = frame_done & ~drop;
    rd_next    = rd_ptr + AW'(1);
    level_next = fifo_level + LW'(wr_en) - LW'(pop);
  end

  // Accumulator, sample counter and active oversampling ratio.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_d        <= 1'b1;
      discard_first <= 1'b1;
      start_pending <= 1'b1;
      osr_act       <= 3'd0;
      acc           <= '0;
      count         <= '0;
    end else begin
      conv_d <= conv_finished;
      if (start_pending) begin
        osr_act       <= osr_eff;
        start_pending <= 1'b0;
      end
      if (strobe && discard_first) discard_first <= 1'b0;
      if (frame_done) begin
        acc     <= '0;
        count   <= '0;
        osr_act <= osr_eff;
      end else if (sample) begin
        acc   <= sum;
        count <= count + CNT_W'(1);
      end
    end
  end

  // FIFO storage; no reset needed since contents are qualified by the level.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr] <= word;
  end

  // FIFO pointers, level, registered head word and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_next;
      fifo_level <= level_next;
      out_valid  <= (level_next != '0);
      if (pop) begin
        if (fifo_level > LW'(1)) data_out <= mem[rd_next];
        else if (wr_en)          data_out <= word;
      end else if (fifo_level == '0 && wr_en) begin
        data_out <= word;
      end
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_result_decimator.sv
// Self-checking bench for adc_result_decimator: directed scenarios plus
// randomized traffic against a queue-based behavioural model.
module tb_adc_result_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic        conv_finished;
  logic [11:0] result;
  logic [2:0]  osr_control;
  logic [15:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        overflow_clr;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_prev_cf;
  int m_discard;
  int m_pending;
  int m_osr;
  int m_sum;
  int m_n;
  int m_q[$];
  int m_dout;
  int m_ovf;

  adc_result_decimator dut (
    .clk(clk), .rst(rst), .conv_finished(conv_finished), .result(result),
    .osr_control(osr_control), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int strobe, pop, push, word, full;
    if (rst) begin
      m_prev_cf = 1; m_discard = 1; m_pending = 1; m_osr = 0;
      m_sum = 0; m_n = 0; m_q.delete(); m_dout = 0; m_ovf = 0;
      return;
    end
    strobe = (conv_finished && !m_prev_cf) ? 1 : 0;
    m_prev_cf = int'(conv_finished);
    if (m_pending != 0) begin
      m_osr = (osr_control > 4) ? 4 : int'(osr_control);
      m_pending = 0;
    end
    push = 0; word = 0;
    if (strobe != 0) begin
      if (m_discard != 0) m_discard = 0;
      else begin
        m_sum += int'(result);
        m_n++;
        if (m_n == (1 << m_osr)) begin
          word = (m_sum << (4 - m_osr)) & 32'hFFFF;
          push = 1; m_sum = 0; m_n = 0;
          m_osr = (osr_control > 4) ? 4 : int'(osr_control);
        end
      end
    end
    full = (m_q.size() == 4) ? 1 : 0;
    pop = (m_q.size() > 0 && out_ready) ? 1 : 0;
    if (pop != 0) void'(m_q.pop_front());
    if (push != 0 && full != 0 && pop == 0) m_ovf = 1;
    else begin
      if (push != 0) m_q.push_back(word);
      if (overflow_clr) m_ovf = 0;
    end
    if (m_q.size() > 0) m_dout = m_q[0];
  endtask

  // One clock: update model, take the edge, compare every output.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("data_out", int'(data_out), m_dout);
    chk("out_valid", int'(out_valid), (m_q.size() != 0) ? 1 : 0);
    chk("fifo_level", int'(fifo_level), m_q.size());
    chk("overflow", int'(overflow), m_ovf);
  endtask

  task automatic do_reset();
    rst = 1'b1; conv_finished = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic rise(input logic [11:0] v);
    conv_finished = 1'b1; result = v;
    tick();
  endtask

  task automatic fall();
    conv_finished = 1'b0;
    tick();
  endtask

  task automatic strobe(input logic [11:0] v);
    rise(v);
    fall();
  endtask

  initial begin
    rst = 1'b1; conv_finished = 1'b0; result = '0; osr_control = 3'd0;
    out_ready = 1'b1; overflow_clr = 1'b0;

    // Reset state and single-sample frame
    do_reset();
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_level", int'(fifo_level), 0);
    chk("reset_dout", int'(data_out), 0);
    strobe(12'h7FF);
    chk("discard_level", int'(fifo_level), 0);
    rise(12'h123);
    chk("osr0_word", int'(data_out), 16'h1230);
    chk("osr0_valid", int'(out_valid), 1);
    fall();
    chk("osr0_popped", int'(out_valid), 0);

    // osr=2: four samples summed and shifted by two
    osr_control = 3'd2;
    do_reset();
    strobe(12'd0);
    strobe(12'd100); strobe(12'd101); strobe(12'd102);
    chk("osr2_partial", int'(fifo_level), 0);
    rise(12'd103);
    chk("osr2_word", int'(data_out), 1624);
    fall();

    // osr_control=7 clamps to 4
    osr_control = 3'd7;
    do_reset();
    strobe(12'd9);
    for (int i = 0; i < 15; i++) strobe(12'hFFF);
    chk("osr7_partial_valid", int'(out_valid), 0);
    rise(12'hFFF);
    chk("osr7_word", int'(data_out), 16'hFFF0);
    fall();

    // Overflow with consumer stalled, then drain and clear
    osr_control = 3'd0; out_ready = 1'b0;
    do_reset();
    strobe(12'd0);
    for (int i = 1; i <= 5; i++) strobe(12'(i));
    chk("full_level", int'(fifo_level), 4);
    chk("full_ovf", int'(overflow), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_word", int'(data_out), i * 16);
      tick();
    end
    chk("drained_valid", int'(out_valid), 0);
    chk("drained_hold", int'(data_out), 16'h40);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // osr change mid-frame only affects the following frames
    osr_control = 3'd2;
    do_reset();
    strobe(12'd0);
    strobe(12'd1); strobe(12'd2);
    osr_control = 3'd0;
    strobe(12'd3);
    chk("midchg_partial", int'(fifo_level), 0);
    rise(12'd4);
    chk("midchg_word", int'(data_out), 40);
    fall();
    rise(12'd5);
    chk("midchg_single", int'(data_out), 16'h50);
    fall();

    // Reset with stored words discards everything
    out_ready = 1'b0;
    strobe(12'd6); strobe(12'd7);
    chk("pre_rst_level", int'(fifo_level), 2);
    rst = 1'b1; tick();
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_valid", int'(out_valid), 0);
    rst = 1'b0; tick();
    strobe(12'd8);
    chk("rst_discard", int'(fifo_level), 0);

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if (!conv_finished) result = 12'($urandom);
        conv_finished = ~conv_finished;
      end
      if ($urandom_range(0, 60) == 0) osr_control = 3'($urandom_range(0, 7));
      out_ready    = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 7) == 0);
      overflow_clr = ($urandom_range(0, 30) == 0);
      rst          = ($urandom_range(0, 700) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
